wor_rr_arbiter: RTL

Round-robin arbiter with a registered output stage for a shared wired-OR data bus. N requesters each present a W-bit word. The block grants one requester at a time for a burst and resolves the bus as the OR of every source's data masked by its grant bit. The resolved beat is registered onto a valid/ready output that feeds the downstream wor/wand consumer logic.

---
 rtl/wor_arb_pkg.sv | 20 ++
 rtl/wor_rr_arbiter_rr_pick.sv | 33 +++
 rtl/wor_rr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wor_arb_pkg.sv
// Shared constants for the wired-OR round-robin arbiter: state encoding,
// default parameter values and the width helper.
package wor_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_MAX_BURST = 8;

    // Never returns less than 1 so single-value counters still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/wor_rr_arbiter_rr_pick.sv
// Rotate-priority picker: first requester found searching upward from
// last_winner+1 with wrap-around.
module rr_pick
    import wor_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int LW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last_winner,
    output logic [N-1:0]  pick,
    output logic [LW-1:0] pick_idx,
    output logic          pick_valid
);

    always_comb begin
        int slot;
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            slot = int'(last_winner) + k;
            if (slot >= N) slot = slot - N;
            if (!pick_valid && req[slot[LW-1:0]]) begin
                pick_valid            = 1'b1;
                pick_idx              = slot[LW-1:0];
                pick[slot[LW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wor_rr_arbiter.sv
// Round-robin burst arbiter resolving a wired-OR bus into a registered
// valid/ready stage. Define WOR_ARB_PARITY_EN to add the registered out_par output.
module wor_rr_arbiter
    import wor_arb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
`ifdef WOR_ARB_PARITY_EN
    ,
    output logic           out_par
`endif
);

    localparam int LW = clog2(N);
    localparam int CW = clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [LW-1:0] LW_RESET = LW'(N - 1);

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [LW-1:0] gnt_idx_q, gnt_idx_d;
    logic [LW-1:0] last_winner_q, last_winner_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          par_q, par_d;

    logic [N-1:0]  pick;
    logic [LW-1:0] pick_idx;
    logic          pick_valid;
    logic [W-1:0]  bus;
    logic          busy, stage_free, beat, release_now;

    rr_pick #(.N(N), .LW(LW)) u_pick (
        .req        (req),
        .last_winner(last_winner_q),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Plain OR of grant-masked words; an empty grant resolves to zero.
    always_comb begin
        bus = '0;
        for (int i = 0; i < N; i++) begin
            bus = bus | (data[i*W +: W] & {W{gnt_q[i]}});
        end
    end

    assign busy        = (state_q == ST_BUSY);
    assign stage_free  = ~out_valid_q | out_ready;
    assign beat        = busy & (|(req & gnt_q)) & stage_free;
    assign release_now = beat & ((|(last & gnt_q)) | (beat_cnt_q == CNT_LAST));

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        par_d         = par_q;

        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                gnt_d     = pick;
                gnt_idx_d = pick_idx;
                state_d   = ST_BUSY;
            end
        end else if (release_now) begin
            gnt_d         = '0;
            last_winner_d = gnt_idx_q;
            beat_cnt_d    = '0;
            state_d       = ST_IDLE;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        if (beat) begin
            out_data_d  = bus;
            out_valid_d = 1'b1;
            par_d       = ^bus;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            last_winner_q <= LW_RESET;
            beat_cnt_q    <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            par_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            par_q         <= par_d;
        end
    end

    assign gnt       = gnt_q;
    assign in_ready  = busy ? (gnt_q & {N{stage_free}}) : '0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef WOR_ARB_PARITY_EN
    assign out_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule
